// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the rx_frame_unpacker slice.
// Build option RX_FRAME_CRC8_EN selects CRC-8 instead of the modulo-256 sum.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SYNC = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_CSUM = 2'd3;

    localparam logic [4:0] SYNC_IDX = 5'd0;
    localparam logic [4:0] LEN_IDX  = 5'd1;
    localparam logic [4:0] PAY_BASE = 5'd2;
    localparam logic [4:0] CSUM_IDX = 5'd31;

    // CHECK counter value of the evaluate cycle, after bytes 1..30 are added
    localparam logic [4:0] EVAL_CNT = 5'd30;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Byte 0 sits in the top bits of the frame
    function automatic logic [7:0] frame_byte(input logic [255:0] frame, input logic [4:0] idx);
        logic [255:0] w_shifted;
        w_shifted = frame << {idx, 3'b000};
        return w_shifted[255:248];
    endfunction

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] w_c;
        w_c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            w_c = w_c[7] ? ((w_c << 1) ^ CRC8_POLY) : (w_c << 1);
        end
        return w_c;
    endfunction

endpackage

// File: rtl/rx_frame_checksum.sv
// Byte-serial frame checksum accumulator: modulo-256 sum by default,
// CRC-8 (poly 0x07, init 0, MSB first) when RX_FRAME_CRC8_EN is defined.
module rx_frame_checksum
    import rx_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    output logic [7:0] o_acc
);

    logic [7:0] r_acc;
    logic [7:0] w_next;

    always_comb begin
`ifdef RX_FRAME_CRC8_EN
        w_next = crc8_update(r_acc, i_byte);
`else
        w_next = r_acc + i_byte;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/rx_frame_unpacker.sv
// Latches a 256-bit received frame, validates sync/length/checksum and streams the
// payload over valid/ready. Checksum flavour chosen by RX_FRAME_CRC8_EN.
module rx_frame_unpacker
    import rx_frame_pkg::*;
#(
    parameter int unsigned FRAME_W   = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN   = 29
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frameIn,
    input  logic               frameValid,
    output logic [7:0]         byteOut,
    output logic               byteValid,
    input  logic               byteReady,
    output logic               frameDone,
    output logic               frameErr,
    output logic [1:0]         errCode,
    output logic               busy,
    output logic [7:0]         dropCount
);

    state_t             r_state;
    logic [FRAME_W-1:0] r_frame;
    logic [4:0]         r_cnt;
    logic [4:0]         r_idx;
    logic [1:0]         r_errCode;
    logic [7:0]         r_dropCount;

    logic [7:0] w_sync;
    logic [7:0] w_len;
    logic [7:0] w_csum;
    logic [7:0] w_acc;
    logic [7:0] w_addByte;
    logic [7:0] w_payByte;
    logic       w_accClear;
    logic       w_accEn;
    logic       w_lastByte;

    assign w_sync    = frame_byte(r_frame, SYNC_IDX);
    assign w_len     = frame_byte(r_frame, LEN_IDX);
    assign w_csum    = frame_byte(r_frame, CSUM_IDX);
    // r_cnt 0..29 walks bytes 1..30
    assign w_addByte = frame_byte(r_frame, r_cnt + LEN_IDX);
    assign w_payByte = frame_byte(r_frame, r_idx + PAY_BASE);

    assign w_accClear = (r_state == ST_IDLE) && frameValid;
    assign w_accEn    = (r_state == ST_CHECK) && (r_cnt != EVAL_CNT);
    assign w_lastByte = ({3'b000, r_idx} == (w_len - 8'd1));

    rx_frame_checksum u_checksum (
        .clk     (clk),
        .rst_n   (rst),
        .i_clear (w_accClear),
        .i_en    (w_accEn),
        .i_byte  (w_addByte),
        .o_acc   (w_acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_frame     <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_errCode   <= ERR_NONE;
            r_dropCount <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frameValid) begin
                        r_frame <= frameIn;
                        r_cnt   <= '0;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (r_cnt != EVAL_CNT) begin
                        r_cnt <= r_cnt + 5'd1;
                    end else if (w_sync != SYNC_BYTE) begin
                        r_errCode <= ERR_SYNC;
                        r_state   <= ST_ERR;
                    end else if (w_len > 8'(MAX_LEN)) begin
                        r_errCode <= ERR_LEN;
                        r_state   <= ST_ERR;
                    end else if (w_acc != w_csum) begin
                        r_errCode <= ERR_CSUM;
                        r_state   <= ST_ERR;
                    end else begin
                        r_errCode <= ERR_NONE;
                        r_idx     <= '0;
                        r_state   <= (w_len == 8'd0) ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (byteReady) begin
                        if (w_lastByte) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Any frameValid outside the registered IDLE state is a lost frame
            if (frameValid && (r_state != ST_IDLE) && (r_dropCount != 8'hFF)) begin
                r_dropCount <= r_dropCount + 8'd1;
            end
        end
    end

    assign byteValid = (r_state == ST_STREAM);
    assign byteOut   = byteValid ? w_payByte : '0;
    assign frameDone = (r_state == ST_DONE);
    assign frameErr  = (r_state == ST_ERR);
    assign errCode   = r_errCode;
    assign busy      = (r_state != ST_IDLE);
    assign dropCount = r_dropCount;

endmodule
